vc_wrr_arbiter: RTL

VC_WRR_ARBITER -- requirements
Module: vc_wrr_arbiter

---
 rtl/vc_wrr_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/vc_wrr_arbiter.sv
// Two-VC weighted round-robin arbiter: pops bursts of up to weight_vcX words per grant and forwards them registered.
// Optional grant-word statistics counters are built when VC_WRR_ARBITER_STATS_EN is defined.
module vc_wrr_arbiter #(
    parameter int DATA_WIDTH   = 6,
    parameter int WEIGHT_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WEIGHT_WIDTH-1:0] weight_vc0,
    input  logic [WEIGHT_WIDTH-1:0] weight_vc1,
    input  logic                    empty_vc0,
    input  logic                    empty_vc1,
    input  logic [DATA_WIDTH-1:0]   data_vc0,
    input  logic [DATA_WIDTH-1:0]   data_vc1,
    input  logic                    pausa_d0,
    input  logic                    pausa_d1,
    output logic                    pop_vc0,
    output logic                    pop_vc1,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    valid_out,
    output logic [1:0]              grant_vc,
    output logic [7:0]              cnt_vc0,
    output logic [7:0]              cnt_vc1
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SERVE0 = 2'b01,
        SERVE1 = 2'b10
    } state_t;

    localparam logic [WEIGHT_WIDTH-1:0] ONE = WEIGHT_WIDTH'(1);

    state_t                  state;
    state_t                  state_nxt;
    logic [WEIGHT_WIDTH-1:0] credit;
    logic [WEIGHT_WIDTH-1:0] credit_nxt;
    logic [WEIGHT_WIDTH-1:0] load_w0;
    logic [WEIGHT_WIDTH-1:0] load_w1;
    logic                    halt;
    logic                    grant_end;
    logic                    pop_pend;
    logic                    pop_src;

    assign halt     = pausa_d0 | pausa_d1;
    assign grant_vc = state;

    // A zero weight would starve the VC, so it is promoted to a quota of one.
    assign load_w0 = (weight_vc0 == '0) ? ONE : weight_vc0;
    assign load_w1 = (weight_vc1 == '0) ? ONE : weight_vc1;

    assign pop_vc0 = (state == SERVE0) & ~empty_vc0 & ~halt;
    assign pop_vc1 = (state == SERVE1) & ~empty_vc1 & ~halt;

    always_comb begin
        state_nxt  = state;
        credit_nxt = credit;
        grant_end  = 1'b0;
        case (state)
            IDLE: begin
                if (!halt) begin
                    if (!empty_vc0) begin
                        state_nxt  = SERVE0;
                        credit_nxt = load_w0;
                    end else if (!empty_vc1) begin
                        state_nxt  = SERVE1;
                        credit_nxt = load_w1;
                    end
                end
            end
            SERVE0: begin
                if (!halt) begin
                    if (empty_vc0) begin
                        grant_end = 1'b1;
                    end else begin
                        credit_nxt = credit - ONE;
                        grant_end  = (credit == ONE);
                    end
                    // Prefer the other VC at grant end so neither can monopolise the output.
                    if (grant_end) begin
                        if (!empty_vc1) begin
                            state_nxt  = SERVE1;
                            credit_nxt = load_w1;
                        end else if (!empty_vc0) begin
                            state_nxt  = SERVE0;
                            credit_nxt = load_w0;
                        end else begin
                            state_nxt  = IDLE;
                            credit_nxt = '0;
                        end
                    end
                end
            end
            SERVE1: begin
                if (!halt) begin
                    if (empty_vc1) begin
                        grant_end = 1'b1;
                    end else begin
                        credit_nxt = credit - ONE;
                        grant_end  = (credit == ONE);
                    end
                    if (grant_end) begin
                        if (!empty_vc0) begin
                            state_nxt  = SERVE0;
                            credit_nxt = load_w0;
                        end else if (!empty_vc1) begin
                            state_nxt  = SERVE1;
                            credit_nxt = load_w1;
                        end else begin
                            state_nxt  = IDLE;
                            credit_nxt = '0;
                        end
                    end
                end
            end
            default: begin
                state_nxt  = IDLE;
                credit_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            credit <= '0;
        end else begin
            state  <= state_nxt;
            credit <= credit_nxt;
        end
    end

    // FIFO read data arrives one cycle after the pop; capture it from the recorded source.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pop_pend  <= 1'b0;
            pop_src   <= 1'b0;
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            pop_pend  <= pop_vc0 | pop_vc1;
            pop_src   <= pop_vc1;
            valid_out <= pop_pend;
            if (pop_pend) begin
                data_out <= pop_src ? data_vc1 : data_vc0;
            end
        end
    end

`ifdef VC_WRR_ARBITER_STATS_EN
    logic [7:0] cnt0_q;
    logic [7:0] cnt1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0_q <= 8'd0;
            cnt1_q <= 8'd0;
        end else begin
            if (pop_vc0 && (cnt0_q != 8'hFF)) begin
                cnt0_q <= cnt0_q + 8'd1;
            end
            if (pop_vc1 && (cnt1_q != 8'hFF)) begin
                cnt1_q <= cnt1_q + 8'd1;
            end
        end
    end

    assign cnt_vc0 = cnt0_q;
    assign cnt_vc1 = cnt1_q;
`else
    assign cnt_vc0 = 8'd0;
    assign cnt_vc1 = 8'd0;
`endif

endmodule
